// File: rtl/rs_syndrome_serial.sv
// ---------------------------------------------------------------------------
// rs_syndrome_serial
//
// Serial Reed-Solomon syndrome calculator.  Received symbols arrive one per
// accepted cycle, highest-degree coefficient first, and are folded into
// `check` Horner accumulators, one per generator root alpha^(genstart+j-1).
// When the last symbol of a frame is accepted, the final accumulators, the
// frame tag, a non-zero flag and a length-error flag are registered into the
// outputs.  osyndrome_val pulses one clock-enabled cycle later.
//
// Parameters
//   n        codeword length in symbols (n <= 2^m-1)
//   check    number of check symbols / syndromes
//   m        symbol width in bits
//   irrpol   primitive polynomial of GF(2^m), including the x^m term
//   genstart first root exponent of the generator polynomial
//   ptr_t    type of the codeword buffer tag
//
// Ports
//   iclk           clock, all state on its rising edge
//   ireset         asynchronous active-high reset
//   iclkena        clock enable; when low no state changes
//   isop/ival/ieop frame delimiters and symbol valid
//   idat           received symbol
//   iptr           codeword tag, sampled with isop
//   osyndrome_val  one-cycle strobe, syndromes ready
//   osyndrome_ptr  tag of the codeword the syndromes belong to
//   osyndrome      syndromes S1..Scheck (S1 in the most significant slot)
//   osyndrome_nz   any syndrome non-zero
//   olen_err       frame length was not exactly n symbols
// ---------------------------------------------------------------------------
module rs_syndrome_serial #(
  parameter int  n        = 240,
  parameter int  check    = 30,
  parameter int  m        = 8,
  parameter int  irrpol   = 285,
  parameter int  genstart = 0,
  parameter type ptr_t    = logic [3:0]
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic                      isop,
  input  logic                      ival,
  input  logic                      ieop,
  input  logic [m-1:0]              idat,
  input  ptr_t                      iptr,
  output logic                      osyndrome_val,
  output ptr_t                      osyndrome_ptr,
  output logic [1:check][m-1:0]     osyndrome,
  output logic                      osyndrome_nz,
  output logic                      olen_err
);

  localparam int            order = (1 << m) - 1;
  localparam int            cw    = $clog2(n + 2);
  localparam logic [m-1:0]  poly  = m'(irrpol);
  localparam logic [cw-1:0] len_n   = cw'(n);
  localparam logic [cw-1:0] len_sat = cw'(n + 1);
  localparam logic [cw-1:0] len_one = cw'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // Column b of the constant multiplier alpha^e: the product alpha^e * x^b.
  // Evaluated at elaboration only, so each multiplier becomes a fixed XOR
  // network of input bits.
  function automatic logic [m-1:0][m-1:0] build_cols(input int e);
    logic [m-1:0][m-1:0] c;
    logic [m-1:0]        v;
    int                  r;
    r = e % order;
    if (r < 0) r += order;
    for (int b = 0; b < m; b++) begin
      v    = '0;
      v[b] = 1'b1;
      for (int k = 0; k < r; k++) begin
        v = (v << 1) ^ (v[m-1] ? poly : '0);
      end
      c[b] = v;
    end
    return c;
  endfunction

  logic [0:0]               state_q;
  logic [cw-1:0]            cnt_q;
  logic [1:check][m-1:0]    acc_q;
  ptr_t                     ptr_q;

  logic [1:check][m-1:0]    acc_hor;
  logic [1:check][m-1:0]    acc_d;
  logic [cw-1:0]            cnt_d;
  ptr_t                     ptr_d;
  logic                     sop_take;
  logic                     dat_take;
  logic                     eop_fire;

  // Horner step per root: acc * alpha^(genstart+j-1) xor idat.
  for (genvar j = 1; j <= check; j++) begin : g_root
    localparam logic [m-1:0][m-1:0] cols = build_cols(genstart + j - 1);
    logic [m-1:0] prod;
    always_comb begin
      prod = '0;
      for (int b = 0; b < m; b++) begin
        if (acc_q[j][b]) prod = prod ^ cols[b];
      end
    end
    assign acc_hor[j] = prod ^ idat;
  end

  // A start symbol is always taken (it restarts any frame in progress);
  // other symbols only count while a frame is open.
  assign sop_take = ival & isop;
  assign dat_take = ival & (isop | (state_q == ST_ACC));
  assign eop_fire = dat_take & ieop;

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_hor;
    cnt_d = (cnt_q == len_sat) ? cnt_q : cnt_q + len_one;
    ptr_d = ptr_q;
    if (isop) begin
      acc_d = {check{idat}};
      cnt_d = len_one;
      ptr_d = iptr;
    end
  end

  // NOTE: the accumulators are ordinary flops, so they take the reset like
  // every other register; a half-accumulated frame never survives a reset.
  // NOTE: all state uses non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      ptr_q         <= '0;
      osyndrome_val <= 1'b0;
      osyndrome_ptr <= '0;
      osyndrome     <= '0;
      osyndrome_nz  <= 1'b0;
      olen_err      <= 1'b0;
    end else if (iclkena) begin
      osyndrome_val <= eop_fire;
      if (dat_take) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      if (sop_take) ptr_q <= iptr;
      if (eop_fire)      state_q <= ST_IDLE;
      else if (sop_take) state_q <= ST_ACC;
      if (eop_fire) begin
        osyndrome     <= acc_d;
        osyndrome_ptr <= ptr_d;
        osyndrome_nz  <= |acc_d;
        olen_err      <= (cnt_d != len_n);
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome_serial.sv
// ---------------------------------------------------------------------------
// tb_rs_syndrome_serial
//
// Bench for rs_syndrome_serial with n=15, check=4, m=4, irrpol=19 (x^4+x+1),
// genstart=0.  A table of single-error frames with hand-computed syndromes is
// replayed first, followed by hand-written sequences for back-to-back frames,
// clock-enable hold, isop restart and mid-frame reset.  Random frames are
// checked against a direct-sum GF(16) model.
// ---------------------------------------------------------------------------
module tb_rs_syndrome_serial;

  localparam int N = 15;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        iclkena;
  logic        isop;
  logic        ival;
  logic        ieop;
  logic [3:0]  idat;
  logic [3:0]  iptr;
  logic        osyndrome_val;
  logic [3:0]  osyndrome_ptr;
  logic [1:4][3:0] osyndrome;
  logic        osyndrome_nz;
  logic        olen_err;

  rs_syndrome_serial #(
    .n(15), .check(4), .m(4), .irrpol(19), .genstart(0)
  ) dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .iclkena       (iclkena),
    .isop          (isop),
    .ival          (ival),
    .ieop          (ieop),
    .idat          (idat),
    .iptr          (iptr),
    .osyndrome_val (osyndrome_val),
    .osyndrome_ptr (osyndrome_ptr),
    .osyndrome     (osyndrome),
    .osyndrome_nz  (osyndrome_nz),
    .olen_err      (olen_err)
  );

  always #5 iclk = ~iclk;

  typedef logic [3:0] sym_arr_t [0:31];

  typedef struct {
    string      name;
    logic [3:0] ptr;
    int         len;
    int         errpos;
    logic [3:0] errval;
    logic [15:0] exp_s;
    logic       exp_nz;
    logic       exp_le;
  } vec_t;

  typedef struct {
    logic [3:0]  ptr;
    logic [15:0] s;
    logic        nz;
    logic        le;
  } rec_t;

  rec_t  seen_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs [0:8];

  // Strobes are counted on the cycle they are consumed (clock enable high).
  always @(negedge iclk) begin
    if (!ireset && osyndrome_val && iclkena)
      seen_q.push_back('{osyndrome_ptr, osyndrome, osyndrome_nz, olen_err});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] apow(input int e);
    logic [3:0] r;
    r = 4'h1;
    for (int k = 0; k < (e % 15); k++) r = gmul(r, 4'h2);
    return r;
  endfunction

  // Direct evaluation of Sj = sum r_i * alpha^((j-1)*(len-1-i)).
  function automatic logic [15:0] model_synd(input sym_arr_t s, input int len);
    logic [15:0] r;
    logic [3:0]  sj;
    r = '0;
    for (int j = 1; j <= 4; j++) begin
      sj = '0;
      for (int i = 0; i < len; i++) sj = sj ^ gmul(s[i], apow((j - 1) * (len - 1 - i)));
      r = {r[11:0], sj};
    end
    return r;
  endfunction

  task automatic send_frame(input logic [3:0] ptr, input sym_arr_t s, input int len,
                            input bit gaps, input bit with_eop);
    bit en;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          ival    = 1'b0;
          isop    = 1'($urandom);
          ieop    = 1'($urandom);
          idat    = 4'($urandom);
          iclkena = 1'b1;
          tick();
        end
      end
      ival = 1'b1;
      isop = (i == 0);
      ieop = with_eop && (i == len - 1);
      idat = s[i];
      iptr = (i == 0) ? ptr : 4'($urandom);
      if (gaps) begin
        do begin
          iclkena = ($urandom_range(0, 3) != 0);
          en      = iclkena;
          tick();
        end while (!en);
      end else begin
        iclkena = 1'b1;
        tick();
      end
    end
    ival    = 1'b0;
    isop    = 1'b0;
    ieop    = 1'b0;
    iclkena = 1'b1;
  endtask

  task automatic wait_strobes(input string name, input int k);
    int budget;
    budget = 60;
    while (seen_q.size() < k && budget > 0) begin
      tick();
      budget--;
    end
    repeat (3) tick();
    check({name, "_strobe_count"}, seen_q.size(), k);
  endtask

  task automatic check_rec(input string name, input logic [3:0] ptr, input logic [15:0] s,
                           input logic nz, input logic le);
    rec_t r;
    if (seen_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_missing: got no strobe expected one", name);
    end else begin
      r = seen_q.pop_front();
      check({name, "_ptr"}, r.ptr, ptr);
      check({name, "_synd"}, r.s, s);
      check({name, "_nz"}, r.nz, nz);
      check({name, "_len_err"}, r.le, le);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    sym_arr_t s;
    sym_arr_t s2;
    logic [15:0] e1;
    logic [15:0] e2;

    //            name          ptr  len errpos val  S1S2S3S4   nz  len_err
    vecs[0] = '{"all_zero",    4'd3, 15, -1, 4'h0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{"err_last",    4'd5, 15, 14, 4'h1, 16'h1111, 1'b1, 1'b0};
    vecs[2] = '{"err_first",   4'd6, 15,  0, 4'h1, 16'h19DF, 1'b1, 1'b0};
    vecs[3] = '{"err_deg1",    4'd8, 15, 13, 4'h1, 16'h1248, 1'b1, 1'b0};
    vecs[4] = '{"err_last_v2", 4'd9, 15, 14, 4'h2, 16'h2222, 1'b1, 1'b0};
    vecs[5] = '{"err_deg2",    4'hA, 15, 12, 4'h1, 16'h143C, 1'b1, 1'b0};
    vecs[6] = '{"short_14",    4'd7, 14, -1, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{"long_16",     4'hB, 16, -1, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{"single_sym",  4'hC,  1,  0, 4'h5, 16'h5555, 1'b1, 1'b1};

    ireset  = 1'b1;
    iclkena = 1'b1;
    isop    = 1'b0;
    ival    = 1'b0;
    ieop    = 1'b0;
    idat    = '0;
    iptr    = '0;
    repeat (3) tick();
    check("reset_val", osyndrome_val, 1'b0);
    check("reset_synd", osyndrome, 16'h0);
    check("reset_ptr", osyndrome_ptr, 4'h0);
    check("reset_nz_le", {osyndrome_nz, olen_err}, 2'b00);
    ireset = 1'b0;
    repeat (2) tick();

    // Table-driven single-error frames.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 32; i++) s[i] = '0;
      if (vecs[v].errpos >= 0) s[vecs[v].errpos] = vecs[v].errval;
      send_frame(vecs[v].ptr, s, vecs[v].len, 1'b0, 1'b1);
      wait_strobes(vecs[v].name, 1);
      check_rec(vecs[v].name, vecs[v].ptr, vecs[v].exp_s, vecs[v].exp_nz, vecs[v].exp_le);
    end

    // Outputs hold between strobes.
    repeat (5) tick();
    check("hold_synd", osyndrome, 16'h5555);
    check("hold_flags", {osyndrome_val, osyndrome_ptr, osyndrome_nz, olen_err}, {1'b0, 4'hC, 1'b1, 1'b1});

    // Back-to-back random frames, tags 1 and 2, random enable/valid gaps.
    for (int i = 0; i < 32; i++) begin
      s[i]  = 4'($urandom);
      s2[i] = 4'($urandom);
    end
    e1 = model_synd(s, N);
    e2 = model_synd(s2, N);
    send_frame(4'd1, s, N, 1'b1, 1'b1);
    send_frame(4'd2, s2, N, 1'b1, 1'b1);
    wait_strobes("b2b_gaps", 2);
    check_rec("b2b_gaps_a", 4'd1, e1, |e1, 1'b0);
    check_rec("b2b_gaps_b", 4'd2, e2, |e2, 1'b0);

    // Back-to-back with no bubble at all.
    for (int i = 0; i < 32; i++) begin
      s[i]  = 4'($urandom);
      s2[i] = 4'($urandom);
    end
    e1 = model_synd(s, N);
    e2 = model_synd(s2, N);
    send_frame(4'd4, s, N, 1'b0, 1'b1);
    send_frame(4'd5, s2, N, 1'b0, 1'b1);
    wait_strobes("b2b_tight", 2);
    check_rec("b2b_tight_a", 4'd4, e1, |e1, 1'b0);
    check_rec("b2b_tight_b", 4'd5, e2, |e2, 1'b0);

    // Strobe held while the clock enable is low, then one qualified cycle.
    for (int i = 0; i < 32; i++) s[i] = '0;
    s[14] = 4'h3;
    send_frame(4'd6, s, N, 1'b0, 1'b1);
    iclkena = 1'b0;
    repeat (3) tick();
    check("ena_low_val_held", osyndrome_val, 1'b1);
    iclkena = 1'b1;
    tick();
    check("ena_high_val_drop", osyndrome_val, 1'b0);
    wait_strobes("ena_hold", 1);
    check_rec("ena_hold", 4'd6, 16'h3333, 1'b1, 1'b0);

    // isop restart at symbol 7: only the new frame is reported.
    for (int i = 0; i < 32; i++) s[i] = 4'($urandom);
    send_frame(4'd9, s, 7, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) s[i] = '0;
    s[0] = 4'h1;
    send_frame(4'hA, s, N, 1'b0, 1'b1);
    wait_strobes("restart", 1);
    check_rec("restart", 4'hA, 16'h19DF, 1'b1, 1'b0);

    // Reset at symbol 10: outputs clear at once, no strobe for the frame.
    for (int i = 0; i < 32; i++) s[i] = 4'($urandom);
    send_frame(4'hD, s, 10, 1'b0, 1'b0);
    ival   = 1'b1;
    idat   = s[10];
    ireset = 1'b1;
    #1;
    check("midreset_synd", osyndrome, 16'h0);
    check("midreset_flags", {osyndrome_val, osyndrome_ptr, osyndrome_nz, olen_err}, 7'h0);
    tick();
    ival   = 1'b0;
    tick();
    ireset = 1'b0;
    repeat (2) tick();
    ival = 1'b1;
    ieop = 1'b1;
    idat = 4'hF;
    tick();
    ival = 1'b0;
    ieop = 1'b0;
    wait_strobes("midreset_none", 0);
    for (int i = 0; i < 32; i++) s[i] = 4'($urandom);
    e1 = model_synd(s, N);
    send_frame(4'hE, s, N, 1'b0, 1'b1);
    wait_strobes("post_reset", 1);
    check_rec("post_reset", 4'hE, e1, |e1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_serial.md
RS_SYNDROME_SERIAL -- requirements
Module: rs_syndrome_serial

Interface
REQ-001 SHALL have parameter n, default 240, codeword length in symbols (n <= 2^m-1).
REQ-002 SHALL have parameter check, default 30, number of check symbols and syndromes.
REQ-003 SHALL have parameter m, default 8, symbol width in bits.
REQ-004 SHALL have parameter irrpol, default 285, GF(2^m) primitive polynomial.
REQ-005 SHALL have parameter genstart, default 0, first root exponent of the generator polynomial.
REQ-006 SHALL have port iclk  input  1  clock; all state on its rising edge.
REQ-007 SHALL have port ireset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port iclkena  input  1  clock enable; when low, no state changes.
REQ-009 SHALL have port isop  input  1  first symbol of codeword, qualified by ival.
REQ-010 SHALL have port ival  input  1  symbol valid.
REQ-011 SHALL have port ieop  input  1  last symbol of codeword, qualified by ival.
REQ-012 SHALL have port idat  input  m  received symbol, highest-degree coefficient first.
REQ-013 SHALL have port iptr  input  ptr_t  codeword buffer tag, sampled with isop.
REQ-014 SHALL have port osyndrome_val  output  1  one-cycle strobe, syndromes ready.
REQ-015 SHALL have port osyndrome_ptr  output  ptr_t  tag of the codeword the syndromes belong to.
REQ-016 SHALL have port osyndrome  output  m x [1:check]  syndromes S1..Scheck.
REQ-017 SHALL have port osyndrome_nz  output  1  high when any syndrome is non-zero.
REQ-018 SHALL have port olen_err  output  1  high when the frame length was not exactly n symbols.

Function
REQ-019 SHALL compute Sj = sum over i of r_i * alpha^((genstart+j-1)*(n-1-i)), j=1..check, by Horner: acc_j <= acc_j*alpha^(genstart+j-1) xor idat.
REQ-020 SHALL load acc_j <= idat (discard prior accumulation) on a symbol with ival&isop.
REQ-021 SHALL count accepted symbols with a counter cleared to 1 on isop and saturating at n+1.
REQ-022 SHALL track states IDLE and ACC; IDLE->ACC on ival&isop&!ieop; ACC->IDLE on ival&ieop.
REQ-023 SHALL ignore ival symbols without isop while in IDLE.
REQ-024 SHALL treat isop in ACC as abort of the current frame and restart, producing no output for the aborted frame.
REQ-025 SHALL, on ival&ieop accepted in ACC (or ival&isop&ieop in IDLE), register the final accumulators, latched tag, nz flag and length flag into the outputs and pulse osyndrome_val on the following cycle (latency 1 clock-enabled cycle after the eop symbol).
REQ-026 SHALL hold osyndrome, osyndrome_ptr, osyndrome_nz, olen_err stable until the next osyndrome_val.
REQ-027 SHALL set olen_err when the count at eop differs from n; syndromes are still output.
REQ-028 SHALL accept a new isop on the cycle directly after ieop (back-to-back frames, no bubble).
REQ-029 SHALL hold osyndrome_val high for exactly one iclkena-qualified cycle; with iclkena low the strobe is held.
REQ-030 SHALL implement GF multiply-by-constant as fixed XOR networks derived from irrpol at elaboration; no table RAM.

Reset
REQ-031 SHALL, on ireset high, asynchronously clear state to IDLE, counter, accumulators, osyndrome_val, osyndrome, osyndrome_ptr, osyndrome_nz and olen_err to 0.
REQ-032 SHALL, on reset mid-frame, discard the frame and produce no osyndrome_val for it.

Verification (n=15, check=4, m=4, irrpol=19, genstart=0 unless stated)
REQ-033 SHALL cover all-zero codeword, iptr=3 -> one strobe, S1..S4=0, osyndrome_nz=0, olen_err=0, osyndrome_ptr=3.
REQ-034 SHALL cover single error value 1 on last symbol -> S1..S4 = 1,1,1,1, osyndrome_nz=1.
REQ-035 SHALL cover single error value 1 on first symbol -> S1..S4 = 0x1,0x9,0xD,0xF.
REQ-036 SHALL cover back-to-back frames with tags 1 and 2 and random iclkena/ival gaps -> two strobes, tags 1 then 2, syndromes match software model.
REQ-037 SHALL cover 14-symbol frame and frame with isop restart at symbol 7 -> first gives olen_err=1; restarted frame gives one strobe with syndromes of the new frame only.
REQ-038 SHALL cover ireset asserted at symbol 10 -> outputs 0 immediately, no strobe; next full frame correct.
